match_timer_ctrl: RTL and testbench

Controller that sequences the pong match countdown. It loads the 8-bit binary match length and converts it to three BCD digits with a multi-cycle conversion. It then counts down once per second, with start, pause and abort control. Its hundreds/tens/ones outputs and status flags drive the 7-segment display path and the game FSM.

---
 rtl/match_timer_ctrl.sv | 168 ++++++++++++++++
 tb/tb_match_timer_ctrl.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/match_timer_ctrl.sv
// match_timer_ctrl: loads an 8-bit match length, converts it to BCD and counts down once per tick.
// Latency: start -> RUN after h+t+1 LOAD cycles; digits decrement every TICK_DIV RUN cycles.
// Backpressure: none; start/pause/abort are single-cycle pulses, priority abort > start > pause > tick.
//
// Ports:
//   clk, reset         system clock, asynchronous active-low reset
//   max_time           match length in seconds (binary), sampled when a start is accepted
//   start/pause/abort  control pulses
//   hund/tens/ones     BCD remaining time (registered)
//   running/paused     state flags (registered)
//   time_up            level while DONE; time_up_pulse one cycle on DONE entry
//   warn               combinational: RUN/PAUSE with remaining time <= WARN_SEC
module match_timer_ctrl #(
  parameter int TICK_DIV = 100000000,
  parameter int WARN_SEC = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] max_time,
  input  logic       start,
  input  logic       pause,
  input  logic       abort,
  output logic [3:0] hund,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       running,
  output logic       paused,
  output logic       time_up,
  output logic       time_up_pulse,
  output logic       warn
);

  localparam int              PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]   TICK_LAST = PW'(TICK_DIV - 1);
  localparam logic [7:0]      WARN_LIM  = 8'(WARN_SEC);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_PAUSE, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [7:0]      rem_q, rem_d;
  logic [3:0]      hund_d, tens_d, ones_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic            pulse_d;
  logic            tick;
  logic            at_last_sec;
  logic [7:0]      low_val;

  assign tick        = (presc_q == TICK_LAST);
  // A tick at 001 (or a stray 000) ends the match instead of wrapping.
  assign at_last_sec = (hund == 4'd0) && (tens == 4'd0) && (ones <= 4'd1);

  // State and datapath registers; flags are registered decodes of the next state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      rem_q         <= 8'd0;
      hund          <= 4'd0;
      tens          <= 4'd0;
      ones          <= 4'd0;
      presc_q       <= '0;
      running       <= 1'b0;
      paused        <= 1'b0;
      time_up       <= 1'b0;
      time_up_pulse <= 1'b0;
    end else begin
      state_q       <= state_d;
      rem_q         <= rem_d;
      hund          <= hund_d;
      tens          <= tens_d;
      ones          <= ones_d;
      presc_q       <= presc_d;
      running       <= (state_d == S_RUN);
      paused        <= (state_d == S_PAUSE);
      time_up       <= (state_d == S_DONE);
      time_up_pulse <= pulse_d;
    end
  end

  // Next-state and next-datapath logic.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    hund_d  = hund;
    tens_d  = tens;
    ones_d  = ones;
    presc_d = presc_q;
    pulse_d = 1'b0;

    if (abort) begin
      state_d = S_IDLE;
      rem_d   = 8'd0;
      hund_d  = 4'd0;
      tens_d  = 4'd0;
      ones_d  = 4'd0;
      presc_d = '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_d = S_LOAD;
            rem_d   = max_time;
            hund_d  = 4'd0;
            tens_d  = 4'd0;
            ones_d  = 4'd0;
            presc_d = '0;
          end
        end

        // Repeated subtraction: one hundreds or tens step per cycle, ones last.
        S_LOAD: begin
          if (rem_q >= 8'd100) begin
            rem_d  = rem_q - 8'd100;
            hund_d = hund + 4'd1;
          end else if (rem_q >= 8'd10) begin
            rem_d  = rem_q - 8'd10;
            tens_d = tens + 4'd1;
          end else begin
            ones_d = rem_q[3:0];
            if (hund == 4'd0 && tens == 4'd0 && rem_q == 8'd0) begin
              state_d = S_DONE;
              pulse_d = 1'b1;
            end else begin
              state_d = S_RUN;
            end
          end
        end

        S_RUN: begin
          if (pause) state_d = S_PAUSE;
          if (tick) begin
            presc_d = '0;
            if (ones != 4'd0) begin
              ones_d = ones - 4'd1;
            end else if (tens != 4'd0) begin
              ones_d = 4'd9;
              tens_d = tens - 4'd1;
            end else if (hund != 4'd0) begin
              ones_d = 4'd9;
              tens_d = 4'd9;
              hund_d = hund - 4'd1;
            end
            // Reaching zero wins over a coincident pause.
            if (at_last_sec) begin
              state_d = S_DONE;
              pulse_d = 1'b1;
            end
          end else begin
            presc_d = presc_q + PW'(1);
          end
        end

        S_PAUSE: begin
          if (pause) state_d = S_RUN;
        end

        default: state_d = S_IDLE;
      endcase
    end
  end

  // Warning output, decoded from registered state and digits.
  always_comb begin
    low_val = ({4'd0, tens} * 8'd10) + {4'd0, ones};
    warn    = ((state_q == S_RUN) || (state_q == S_PAUSE)) &&
              (hund == 4'd0) && (low_val <= WARN_LIM);
  end

endmodule

// File: tb/tb_match_timer_ctrl.sv
// tb_match_timer_ctrl: table-driven directed check of match_timer_ctrl with TICK_DIV=4.
// Each row pulses inputs for one cycle, waits idle cycles, then compares all outputs.
// Hand-written sequences cover async reset mid-RUN.
module tb_match_timer_ctrl;

  logic       clk;
  logic       reset;
  logic [7:0] max_time;
  logic       start, pause, abort;
  logic [3:0] hund, tens, ones;
  logic       running, paused, time_up, time_up_pulse, warn;

  int num_cmp = 0;
  int num_err = 0;

  match_timer_ctrl #(.TICK_DIV(4), .WARN_SEC(10)) dut (
    .clk           (clk),
    .reset         (reset),
    .max_time      (max_time),
    .start         (start),
    .pause         (pause),
    .abort         (abort),
    .hund          (hund),
    .tens          (tens),
    .ones          (ones),
    .running       (running),
    .paused        (paused),
    .time_up       (time_up),
    .time_up_pulse (time_up_pulse),
    .warn          (warn)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // {hund, tens, ones, running, paused, time_up, time_up_pulse, warn}
  logic [16:0] dut_out;
  assign dut_out = {hund, tens, ones, running, paused, time_up, time_up_pulse, warn};

  typedef struct {
    logic        st;
    logic        pa;
    logic        ab;
    logic [7:0]  mt;
    int          idle;
    logic [16:0] exp;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(input logic st, input logic pa, input logic ab,
                             input logic [7:0] mt, input int idle,
                             input logic [3:0] h, input logic [3:0] t, input logic [3:0] o,
                             input logic r, input logic p, input logic tu,
                             input logic tp, input logic w);
    vec_t x;
    x.st   = st;
    x.pa   = pa;
    x.ab   = ab;
    x.mt   = mt;
    x.idle = idle;
    x.exp  = {h, t, o, r, p, tu, tp, w};
    return x;
  endfunction

  task automatic chk(input string name, input logic [16:0] exp);
    num_cmp++;
    if (dut_out !== exp) begin
      num_err++;
      $display("FAIL %s: got h/t/o=%h/%h/%h run=%b pau=%b tu=%b tup=%b warn=%b, want h/t/o=%h/%h/%h run=%b pau=%b tu=%b tup=%b warn=%b",
               name, dut_out[16:13], dut_out[12:9], dut_out[8:5], dut_out[4], dut_out[3],
               dut_out[2], dut_out[1], dut_out[0], exp[16:13], exp[12:9], exp[8:5],
               exp[4], exp[3], exp[2], exp[1], exp[0]);
    end
  endtask

  // Advance one rising edge and settle 1ns past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, want completion");
    $fatal(1, "timeout");
  end

  initial begin
    reset    = 1'b0;
    max_time = 8'd0;
    start    = 1'b0;
    pause    = 1'b0;
    abort    = 1'b0;

    // st pa ab mt idle  h t o  r p tu tp w
    // Scenario: 123 load timing, ignored start/pause in LOAD, first tick, abort.
    tbl.push_back(v(1,0,0,123,  0, 0,0,0, 0,0,0,0,0));
    tbl.push_back(v(1,1,0,  7,  2, 1,2,0, 0,0,0,0,0));
    tbl.push_back(v(0,0,0,  0,  0, 1,2,3, 1,0,0,0,0));
    tbl.push_back(v(0,0,0,  0,  2, 1,2,3, 1,0,0,0,0));
    tbl.push_back(v(0,0,0,  0,  0, 1,2,2, 1,0,0,0,0));
    tbl.push_back(v(0,0,1,  0,  0, 0,0,0, 0,0,0,0,0));
    // 100 -> 099 borrow, then 011 (no warn) -> 010 (warn).
    tbl.push_back(v(1,0,0,100,  0, 0,0,0, 0,0,0,0,0));
    tbl.push_back(v(0,0,0,  0,  1, 1,0,0, 1,0,0,0,0));
    tbl.push_back(v(0,0,0,  0,  3, 0,9,9, 1,0,0,0,0));
    tbl.push_back(v(0,0,0,  0,351, 0,1,1, 1,0,0,0,0));
    tbl.push_back(v(0,0,0,  0,  3, 0,1,0, 1,0,0,0,1));
    tbl.push_back(v(0,0,1,  0,  0, 0,0,0, 0,0,0,0,0));
    // 3 seconds to DONE, single pulse, level hold, restart from DONE.
    tbl.push_back(v(1,0,0,  3,  0, 0,0,0, 0,0,0,0,0));
    tbl.push_back(v(0,0,0,  0,  0, 0,0,3, 1,0,0,0,1));
    tbl.push_back(v(0,0,0,  0, 10, 0,0,1, 1,0,0,0,1));
    tbl.push_back(v(0,0,0,  0,  0, 0,0,0, 0,0,1,1,0));
    tbl.push_back(v(0,0,0,  0,  0, 0,0,0, 0,0,1,0,0));
    tbl.push_back(v(0,0,0,  0,  5, 0,0,0, 0,0,1,0,0));
    tbl.push_back(v(1,0,0,  3,  0, 0,0,0, 0,0,0,0,0));
    tbl.push_back(v(0,0,0,  0,  0, 0,0,3, 1,0,0,0,1));
    tbl.push_back(v(0,0,1,  0,  0, 0,0,0, 0,0,0,0,0));
    // 050: pause with prescaler frozen at 2, hold, resume -> 049 two cycles later.
    tbl.push_back(v(1,0,0, 50,  0, 0,0,0, 0,0,0,0,0));
    tbl.push_back(v(0,0,0,  0,  5, 0,5,0, 1,0,0,0,0));
    tbl.push_back(v(0,0,0,  0,  0, 0,5,0, 1,0,0,0,0));
    tbl.push_back(v(0,1,0,  0,  0, 0,5,0, 0,1,0,0,0));
    tbl.push_back(v(0,0,0,  0, 19, 0,5,0, 0,1,0,0,0));
    tbl.push_back(v(0,1,0,  0,  0, 0,5,0, 1,0,0,0,0));
    tbl.push_back(v(0,0,0,  0,  0, 0,5,0, 1,0,0,0,0));
    tbl.push_back(v(0,0,0,  0,  0, 0,4,9, 1,0,0,0,0));
    tbl.push_back(v(0,0,1,  0,  0, 0,0,0, 0,0,0,0,0));
    // Zero length: one LOAD cycle then DONE with pulse; abort from DONE.
    tbl.push_back(v(1,0,0,  0,  0, 0,0,0, 0,0,0,0,0));
    tbl.push_back(v(0,0,0,  0,  0, 0,0,0, 0,0,1,1,0));
    tbl.push_back(v(0,0,0,  0,  0, 0,0,0, 0,0,1,0,0));
    tbl.push_back(v(0,0,1,  0,  0, 0,0,0, 0,0,0,0,0));
    // 012: start ignored in RUN, pause coinciding with tick, resume, warn at 010.
    tbl.push_back(v(1,0,0, 12,  0, 0,0,0, 0,0,0,0,0));
    tbl.push_back(v(0,0,0,  0,  1, 0,1,2, 1,0,0,0,0));
    tbl.push_back(v(1,0,0,200,  2, 0,1,2, 1,0,0,0,0));
    tbl.push_back(v(0,1,0,  0,  0, 0,1,1, 0,1,0,0,0));
    tbl.push_back(v(0,0,0,  0,  7, 0,1,1, 0,1,0,0,0));
    tbl.push_back(v(0,1,0,  0,  0, 0,1,1, 1,0,0,0,0));
    tbl.push_back(v(0,0,0,  0,  3, 0,1,0, 1,0,0,0,1));
    tbl.push_back(v(0,0,1,  0,  0, 0,0,0, 0,0,0,0,0));
    // Abort during LOAD: back to idle, no pulse afterwards.
    tbl.push_back(v(1,0,0,123,  1, 1,0,0, 0,0,0,0,0));
    tbl.push_back(v(0,0,1,  0,  0, 0,0,0, 0,0,0,0,0));
    tbl.push_back(v(0,0,0,  0,  6, 0,0,0, 0,0,0,0,0));

    #3;
    chk("reset_state", 17'd0);
    #4;
    reset = 1'b1;
    step();

    for (int i = 0; i < tbl.size(); i++) begin
      start    = tbl[i].st;
      pause    = tbl[i].pa;
      abort    = tbl[i].ab;
      max_time = tbl[i].mt;
      step();
      start = 1'b0;
      pause = 1'b0;
      abort = 1'b0;
      for (int k = 0; k < tbl[i].idle; k++) step();
      chk($sformatf("row%0d", i), tbl[i].exp);
    end

    // Async reset between edges during RUN.
    start    = 1'b1;
    max_time = 8'd123;
    step();
    start = 1'b0;
    repeat (6) step();
    chk("pre_reset_run", {4'd1, 4'd2, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
    #3;
    reset = 1'b0;
    #1;
    chk("async_reset_clear", 17'd0);
    #1;
    reset = 1'b1;
    step();
    chk("idle_after_reset", 17'd0);
    start    = 1'b1;
    max_time = 8'd5;
    step();
    start = 1'b0;
    step();
    chk("restart_after_reset", {4'd0, 4'd0, 4'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", num_cmp, num_err);
    $finish;
  end

endmodule
